sd_wrrmux: RTL

Weighted round-robin multiplexer for the srdy/drdy stream library. It is the parametrised successor to the plain round-robin mux. It merges `inputs` consumer channels onto one producer channel. Each channel gets a configurable number of back-to-back transfers per grant, and the caller can hold a grant across a multi-word packet. It sits between sequence generators or forks and downstream mirrors or FIFOs.

---
 rtl/sd_wrrmux_pkg.sv | 19 +
 rtl/sd_rr_pick.sv | 41 ++++
 rtl/sd_wrrmux.sv | 121 ++++++++++++
 3 files changed

// File: rtl/sd_wrrmux_pkg.sv
// sd_wrrmux_pkg -- shared constants and helpers for the weighted round-robin mux.
//   clog2()      : index width for a channel count (sizes cur/last/idx)
//   XFER_CNT_W   : width of the optional per-channel transfer counters
//   XFER_CNT_MAX : saturation value of those counters
package sd_wrrmux_pkg;

   localparam int          XFER_CNT_W   = 16;
   localparam logic [15:0] XFER_CNT_MAX = 16'hFFFF;

   // Bits needed to hold an index in 0..n-1 (at least 1).
   function automatic int clog2(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++)
         if ((1 << i) < n) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/sd_rr_pick.sv
// sd_rr_pick -- combinational round-robin picker.
// Searches req starting at last+1 and wrapping, returns the first requester.
// Ports:
//   req   [inputs]  : per-channel requests
//   last  [iw]      : index of the most recently released channel
//   grant [inputs]  : one-hot winner (0 when nothing requests)
//   idx   [iw]      : encoded winner (0 when nothing requests)
//   any             : at least one request present
module sd_rr_pick
   import sd_wrrmux_pkg::*;
#(
   parameter int inputs = 4,
   parameter int iw     = clog2(inputs)
)(
   input  logic [inputs-1:0] req,
   input  logic [iw-1:0]     last,
   output logic [inputs-1:0] grant,
   output logic [iw-1:0]     idx,
   output logic              any
);

   // Walk from the farthest candidate back to the nearest so the nearest
   // requester after 'last' is the one left standing.
   always_comb begin
      int ch;
      ch    = 0;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int k = inputs; k >= 1; k--) begin
         ch = (int'(last) + k) % inputs;
         if (req[ch]) begin
            grant     = '0;
            grant[ch] = 1'b1;
            idx       = iw'(ch);
            any       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sd_wrrmux.sv
// sd_wrrmux -- weighted round-robin multiplexer for srdy/drdy streams.
// Merges 'inputs' consumer channels onto one producer channel. Each grant
// allows weight(n) back-to-back transfers (0 counts as 1); c_rearb=0 locks
// the current grant across a multi-word packet.
// Optional feature macro: SDLIB_WRRMUX_STATS_EN adds p_xfer_cnt, per-channel
// saturating 16-bit transfer counters.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   c_srdy/c_drdy       : per-channel handshake (c_drdy at most one-hot)
//   c_data              : channel n at [n*width +: width]
//   c_rearb             : 1 = may re-arbitrate after this transfer
//   c_weight            : channel n weight at [n*wt_sz +: wt_sz]
//   p_srdy/p_drdy/p_data: merged producer stream
//   p_grant             : one-hot owner of p_srdy/p_data
//   p_xfer_cnt          : (stats build) channel n count at [n*16 +: 16]
module sd_wrrmux
   import sd_wrrmux_pkg::*;
#(
   parameter int width  = 8,
   parameter int inputs = 4,
   parameter int wt_sz  = 4
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic [inputs-1:0]         c_srdy,
   output logic [inputs-1:0]         c_drdy,
   input  logic [width*inputs-1:0]   c_data,
   input  logic                      c_rearb,
   input  logic [wt_sz*inputs-1:0]   c_weight,
   output logic                      p_srdy,
   input  logic                      p_drdy,
   output logic [width-1:0]          p_data,
   output logic [inputs-1:0]         p_grant
`ifdef SDLIB_WRRMUX_STATS_EN
   ,output logic [XFER_CNT_W*inputs-1:0] p_xfer_cnt
`endif
);

   localparam int iw = clog2(inputs);

   logic              held;
   logic [iw-1:0]     cur, last, sel, pick_idx;
   logic [wt_sz-1:0]  credit, sel_wt;
   logic [inputs-1:0] pick_grant, cur_oh;
   logic              pick_any, xfer;

   sd_rr_pick #(.inputs(inputs), .iw(iw)) u_pick (
      .req   (c_srdy),
      .last  (last),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   always_comb begin
      cur_oh      = '0;
      cur_oh[cur] = 1'b1;
   end

   // With no request sel falls to pick_idx=0, so p_data shows channel 0.
   assign sel     = held ? cur : pick_idx;
   assign p_grant = held ? cur_oh : pick_grant;
   assign p_srdy  = held ? c_srdy[cur] : pick_any;
   assign p_data  = c_data[int'(sel)*width +: width];
   assign c_drdy  = p_grant & {inputs{p_drdy}};
   assign sel_wt  = c_weight[int'(sel)*wt_sz +: wt_sz];
   assign xfer    = p_srdy & p_drdy;

   always_ff @(posedge clk) begin
      if (reset) begin
         held   <= 1'b0;
         cur    <= '0;
         last   <= iw'(inputs-1);
         credit <= '0;
      end else if (!held) begin
         if (xfer) begin
            // First transfer of a grant already spends one credit unless
            // the caller is locking the grant for a packet.
            if (!c_rearb || sel_wt > wt_sz'(1)) begin
               held   <= 1'b1;
               cur    <= sel;
               credit <= c_rearb ? sel_wt - wt_sz'(1) : sel_wt;
            end else begin
               last <= sel;
            end
         end
      end else begin
         if (xfer) begin
            if (c_rearb) begin
               if (credit > wt_sz'(1)) begin
                  credit <= credit - wt_sz'(1);
               end else begin
                  held <= 1'b0;
                  last <= cur;
               end
            end
         end else if (!c_srdy[cur] && c_rearb) begin
            // Owner went idle: give up the rest of its credit.
            held <= 1'b0;
            last <= cur;
         end
      end
   end

`ifdef SDLIB_WRRMUX_STATS_EN
   logic [inputs-1:0][XFER_CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (xfer) begin
         for (int i = 0; i < inputs; i++)
            if (p_grant[i] && cnt[i] != XFER_CNT_MAX)
               cnt[i] <= cnt[i] + 16'd1;
      end
   end

   assign p_xfer_cnt = cnt;
`endif

endmodule
